// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation and
// FSM state encodings, the iteration count and small sign helpers.
package muldiv_unit_pkg;

    localparam int ITER_DEFAULT = 32;

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10
    } state_e;

    // Two's-complement negation of a 32-bit word.
    function automatic logic [31:0] neg32(input logic [31:0] x);
        return ~x + 32'd1;
    endfunction

    // Magnitude of a signed 32-bit word; 0x80000000 maps to itself, which
    // reads correctly as an unsigned magnitude.
    function automatic logic [31:0] abs32(input logic [31:0] x);
        return x[31] ? neg32(x) : x;
    endfunction

endpackage

// File: rtl/adder_32bit.sv
// 32-bit ripple-carry adder used as the shared iteration adder.
module adder_32bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);
    logic [32:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < 32; i++) begin : g_bit
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[32];

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding the HI/LO registers. Operands are
// reduced to magnitudes at start, iterated 32 times through one shared adder
// (shift-add multiply, restoring divide) and sign-corrected in FIX.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int ITER = ITER_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] srca,
    input  logic [31:0] srcb,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wd,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam int CW = $clog2(ITER + 1);

    state_e        state;
    op_e           opr;
    logic [CW-1:0] count;
    logic [31:0]   acc;     // multiply: upper product half; divide: remainder
    logic [31:0]   mq;      // multiply: multiplier/low half; divide: dividend->quotient
    logic [31:0]   opb;     // multiplicand magnitude or divisor magnitude
    logic [31:0]   raw_a;   // unmodified srca, returned as hi on divide by zero
    logic          neg_p;
    logic          neg_q;
    logic          neg_r;
    logic          div_zero;

    logic          is_div;
    logic [32:0]   r_sh;
    logic [31:0]   add_a;
    logic [31:0]   add_b;
    logic          add_cin;
    logic [31:0]   add_sum;
    logic          add_cout;
    logic          sub_ok;

    logic [63:0]   prod;
    logic [63:0]   prod_fix;
    logic [31:0]   quo_fix;
    logic [31:0]   rem_fix;

    logic          start_signed;
    logic          start_div;

    assign is_div = (opr == OP_DIVU) || (opr == OP_DIV);
    assign r_sh   = {acc, mq[31]};
    assign sub_ok = r_sh[32] | add_cout;

    assign start_signed = (op == OP_MULT) || (op == OP_DIV);
    assign start_div    = (op == OP_DIVU) || (op == OP_DIV);

    // Select adder operands: conditional add for multiply, trial subtract for divide.
    always_comb begin
        add_a   = acc;
        add_b   = mq[0] ? opb : 32'd0;
        add_cin = 1'b0;
        if (is_div) begin
            add_a   = r_sh[31:0];
            add_b   = ~opb;
            add_cin = 1'b1;
        end
    end

    adder_32bit u_adder (
        .a    (add_a),
        .b    (add_b),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Sign correction of the magnitude results, applied in FIX.
    always_comb begin
        prod     = {acc, mq};
        prod_fix = neg_p ? (~prod + 64'd1) : prod;
        quo_fix  = neg_q ? neg32(mq)  : mq;
        rem_fix  = neg_r ? neg32(acc) : acc;
    end

    // Control FSM with iteration datapath and HI/LO registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            opr      <= OP_MULTU;
            count    <= '0;
            acc      <= '0;
            mq       <= '0;
            opb      <= '0;
            raw_a    <= '0;
            neg_p    <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        opr      <= op_e'(op);
                        raw_a    <= srca;
                        count    <= '0;
                        acc      <= '0;
                        neg_p    <= (op == OP_MULT) & (srca[31] ^ srcb[31]);
                        neg_q    <= (op == OP_DIV)  & (srca[31] ^ srcb[31]);
                        neg_r    <= (op == OP_DIV)  & srca[31];
                        div_zero <= start_div & (srcb == 32'd0);
                        if (start_div) begin
                            mq  <= start_signed ? abs32(srca) : srca;
                            opb <= start_signed ? abs32(srcb) : srcb;
                        end else begin
                            mq  <= start_signed ? abs32(srcb) : srcb;
                            opb <= start_signed ? abs32(srca) : srca;
                        end
                        busy  <= 1'b1;
                        state <= S_CALC;
                    end else begin
                        if (hi_we) hi <= wd;
                        if (lo_we) lo <= wd;
                    end
                end
                S_CALC: begin
                    if (is_div) begin
                        acc <= sub_ok ? add_sum : r_sh[31:0];
                        mq  <= {mq[30:0], sub_ok};
                    end else begin
                        acc <= {add_cout, add_sum[31:1]};
                        mq  <= {add_sum[0], mq[31:1]};
                    end
                    count <= count + 1'b1;
                    if (count == CW'(ITER - 1)) state <= S_FIX;
                end
                S_FIX: begin
                    if (div_zero) begin
                        hi <= raw_a;
                        lo <= 32'hFFFF_FFFF;
                    end else if (is_div) begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end else begin
                        hi <= prod_fix[63:32];
                        lo <= prod_fix[31:0];
                    end
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: table of directed vectors, random
// vectors against a native-arithmetic model, and hand-written corner sequences.
// Expected hi/lo are queued at start and compared when done pulses.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] srca;
    logic [31:0] srcb;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wd;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] eh;
        logic [31:0] el;
    } vec_t;

    typedef struct {
        logic [31:0] eh;
        logic [31:0] el;
    } exp_t;

    exp_t sb_q[$];
    vec_t tbl[8];

    muldiv_unit #(.ITER(32)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .srca  (srca),
        .srcb  (srcb),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wd    (wd),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: compare hi/lo against the oldest pending expectation on done.
    always @(negedge clk) begin
        if (!reset && done === 1'b1) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 expected no pending op");
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("result_hi", hi, e.eh);
                chk("result_lo", lo, e.el);
            end
        end
    end

    function automatic exp_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        exp_t r;
        longint sa, sb, p, q, m;
        logic [63:0] t;
        sa = (o == 2'b01 || o == 2'b11) ? longint'($signed(a)) : longint'({32'd0, a});
        sb = (o == 2'b01 || o == 2'b11) ? longint'($signed(b)) : longint'({32'd0, b});
        if (o[1] == 1'b0) begin
            p    = sa * sb;
            t    = 64'(p);
            r.eh = t[63:32];
            r.el = t[31:0];
        end else if (b == 32'd0) begin
            r.eh = a;
            r.el = 32'hFFFF_FFFF;
        end else begin
            q    = sa / sb;
            m    = sa % sb;
            t    = 64'(q);
            r.el = t[31:0];
            t    = 64'(m);
            r.eh = t[31:0];
        end
        return r;
    endfunction

    // hook: 0 none, 1 second start at E10, 2 MTHI/MTLO during busy, 3 lo_we with start
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el, input int hook);
        int lat;
        int nb;
        bit got;
        logic [31:0] ph;
        logic [31:0] pl;
        exp_t e;
        ph = hi;
        pl = lo;
        @(negedge clk);
        start = 1'b1;
        op    = o;
        srca  = a;
        srcb  = b;
        if (hook == 3) begin
            lo_we = 1'b1;
            wd    = 32'hDEAD_BEEF;
        end
        e.eh = eh;
        e.el = el;
        sb_q.push_back(e);
        lat = 0;
        nb  = 0;
        got = 1'b0;
        while (lat < 100 && !got) begin
            @(negedge clk);
            lat++;
            if (busy) nb++;
            if (done) got = 1'b1;
            if (lat == 1) begin
                start = 1'b0;
                if (hook == 3) begin
                    chk("lo_we_with_start", lo, pl);
                    lo_we = 1'b0;
                end
            end
            if (hook == 1 && lat == 10) begin
                start = 1'b1;
                op    = 2'b10;
                srca  = 32'd1;
                srcb  = 32'd1;
            end
            if (hook == 1 && lat == 11) start = 1'b0;
            if (hook == 2 && lat == 5) begin
                hi_we = 1'b1;
                lo_we = 1'b1;
                wd    = 32'hDEAD_BEEF;
            end
            if (hook == 2 && lat == 6) begin
                hi_we = 1'b0;
                lo_we = 1'b0;
                chk("hi_we_busy", hi, ph);
                chk("lo_we_busy", lo, pl);
            end
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL timeout: got no done expected done within 100 cycles");
            void'(sb_q.pop_front());
        end else begin
            chk("latency", 32'(lat), 32'd34);
            chk("busy_cycles", 32'(nb), 32'd33);
        end
        if (hook == 1) begin
            @(negedge clk);
            chk("restart_ignored_busy", {31'd0, busy}, 32'd0);
        end
    endtask

    initial begin
        exp_t m;
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;

        tbl[0] = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        tbl[1] = '{2'b01, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
        tbl[2] = '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        tbl[3] = '{2'b10, 32'd100,       32'd7,         32'd2,         32'd14};
        tbl[4] = '{2'b11, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
        tbl[5] = '{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        tbl[6] = '{2'b10, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF};
        tbl[7] = '{2'b11, 32'hFFFF_FFF0, 32'd0,         32'hFFFF_FFF0, 32'hFFFF_FFFF};

        reset = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        srca  = '0;
        srcb  = '0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        wd    = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);

        // MTHI / MTLO in IDLE
        hi_we = 1'b1;
        wd    = 32'h0000_1234;
        @(negedge clk);
        hi_we = 1'b0;
        chk("mthi_hi", hi, 32'h0000_1234);
        chk("mthi_lo_untouched", lo, 32'd0);
        lo_we = 1'b1;
        wd    = 32'h0000_5678;
        @(negedge clk);
        lo_we = 1'b0;
        chk("mtlo_lo", lo, 32'h0000_5678);
        chk("mtlo_hi_untouched", hi, 32'h0000_1234);

        // directed table
        for (int i = 0; i < 8; i++)
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].eh, tbl[i].el, 0);

        // random vectors against the native-arithmetic model
        for (int i = 0; i < 12; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = (i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
            m  = model(ro, ra, rb);
            run_op(ro, ra, rb, m.eh, m.el, 0);
        end

        // second start at E10 is ignored
        run_op(2'b00, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 1);
        // MTHI/MTLO while busy have no effect
        run_op(2'b01, 32'hFFFF_FFFF, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 2);
        // lo_we in the start cycle is dropped
        run_op(2'b00, 32'd2, 32'd3, 32'd0, 32'd6, 3);

        // reset at E10 aborts the operation
        @(negedge clk);
        start = 1'b1;
        op    = 2'b00;
        srca  = 32'hFFFF_FFFF;
        srcb  = 32'hFFFF_FFFF;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        run_op(2'b00, 32'd6, 32'd7, 32'd0, 32'd42, 0);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
